// File: rtl/read_if.sv
// Request and burst-descriptor handshake bundle for the read burst splitter.
// The design takes the slave modport; its driver takes master.
interface read_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [LEN_WIDTH-1:0]  s_len;
    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [7:0]            m_len;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output s_addr, s_len, s_valid, m_ready,
        input  s_ready, m_addr, m_len, m_valid
    );

    modport slave (
        input  s_addr, s_len, s_valid, m_ready,
        output s_ready, m_addr, m_len, m_valid
    );
endinterface

// File: rtl/read.sv
// AR burst splitter: cuts one (addr, beats) request into AXI-legal bursts.
// Define M_AXI_BURST_SPLIT_4K_EN to keep bursts inside 4 KB pages.
module read #(
    parameter int ADDR_WIDTH      = 64,
    parameter int LEN_WIDTH       = 32,
    parameter int BEAT_BYTES_LOG2 = 6,
    parameter int MAX_BURST_LEN   = 16
) (
    input  logic clk,
    input  logic reset,
    read_if.slave bus,
    output logic busy
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << BEAT_BYTES_LOG2) - ADDR_WIDTH'(1));
    localparam logic [LEN_WIDTH-1:0] MAX_W = LEN_WIDTH'(MAX_BURST_LEN);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  beats_q;
    logic                  s_ready_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [7:0]            m_len_q;
    logic                  m_valid_q;

    logic [LEN_WIDTH-1:0]  beats_d;
    logic [LEN_WIDTH-1:0]  rem_d;
    logic [ADDR_WIDTH-1:0] addr_d;

`ifdef M_AXI_BURST_SPLIT_4K_EN
    logic [12:0] bnd;

    // Beats left before the next 4 KB page; never 0 since cur_addr is beat aligned.
    always_comb begin
        bnd = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> BEAT_BYTES_LOG2;
        beats_d = (rem_q < MAX_W) ? rem_q : MAX_W;
        if (LEN_WIDTH'(bnd) < beats_d) beats_d = LEN_WIDTH'(bnd);
    end
`else
    always_comb begin
        beats_d = (rem_q < MAX_W) ? rem_q : MAX_W;
    end
`endif

    assign rem_d  = rem_q - beats_q;
    assign addr_d = cur_addr_q + (ADDR_WIDTH'(beats_q) << BEAT_BYTES_LOG2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            s_ready_q  <= 1'b0;
            m_addr_q   <= '0;
            m_len_q    <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    // Zero-length requests are consumed here and never leave IDLE.
                    if (s_ready_q && bus.s_valid && bus.s_len != '0) begin
                        cur_addr_q <= bus.s_addr & ADDR_MASK;
                        rem_q      <= bus.s_len;
                        s_ready_q  <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    m_addr_q  <= cur_addr_q;
                    m_len_q   <= 8'(beats_d - LEN_WIDTH'(1));
                    beats_q   <= beats_d;
                    m_valid_q <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    if (bus.m_ready) begin
                        cur_addr_q <= addr_d;
                        rem_q      <= rem_d;
                        m_valid_q  <= 1'b0;
                        if (rem_d == '0) begin
                            s_ready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_len   = m_len_q;
    assign bus.m_valid = m_valid_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_read.sv
// Scoreboard bench for the read burst splitter: directed requests push
// expected bursts; a negedge monitor pops and compares on each handshake.
module tb_read;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    read_if bus ();

    read dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [7:0]  l;
    } burst_t;

    burst_t exp_q[$];
    burst_t mon_e;
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [7:0] l);
        burst_t b;
        b.a = a;
        b.l = l;
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_burst: got addr 0x%0h len %0d want none",
                         bus.m_addr, bus.m_len);
            end else begin
                mon_e = exp_q.pop_front();
                chk("burst_addr", bus.m_addr, mon_e.a);
                chk("burst_len", {56'h0, bus.m_len}, {56'h0, mon_e.l});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [63:0] a, input logic [31:0] n);
        int t;
        bus.s_addr  = a;
        bus.s_len   = n;
        bus.s_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.s_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!bus.s_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got s_ready 0 want 1");
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!(bus.s_ready && !busy && exp_q.size() == 0) && t < 300) begin
            t++;
            @(negedge clk);
        end
        n_vec++;
        if (!(bus.s_ready && !busy && exp_q.size() == 0)) begin
            n_bad++;
            $display("FAIL %s_idle: got s_ready %0b busy %0b pending %0d want 1 0 0",
                     name, bus.s_ready, busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mvalid(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.m_valid && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk({name, "_mvalid_rise"}, {63'h0, bus.m_valid}, 64'h1);
    endtask

    initial begin
        bus.s_addr  = '0;
        bus.s_len   = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;

        #12;
        chk("rst_s_ready", {63'h0, bus.s_ready}, 64'h0);
        chk("rst_m_valid", {63'h0, bus.m_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_m_addr", bus.m_addr, 64'h0);
        chk("rst_m_len", {56'h0, bus.m_len}, 64'h0);

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("s_ready_pre_edge", {63'h0, bus.s_ready}, 64'h0);
        @(negedge clk);
        chk("s_ready_post_rst", {63'h0, bus.s_ready}, 64'h1);
        @(posedge clk);
        #1;

        bus.m_ready = 1'b1;
        push(64'h000, 8'd15);
        push(64'h400, 8'd15);
        push(64'h800, 8'd7);
        send(64'h0, 32'd40);
        wait_idle("len40");

`ifdef M_AXI_BURST_SPLIT_4K_EN
        push(64'hF80, 8'd1);
        push(64'h1000, 8'd7);
`else
        push(64'hF80, 8'd9);
`endif
        send(64'hF80, 32'd10);
        wait_idle("cross4k");

        push(64'h7C0, 8'd2);
        send(64'h7C5, 32'd3);
        wait_idle("unaligned");

`ifdef M_AXI_BURST_SPLIT_4K_EN
        push(64'hFFFF_FFFF_FFFF_FFC0, 8'd0);
        push(64'h0, 8'd0);
`else
        push(64'hFFFF_FFFF_FFFF_FFC0, 8'd1);
`endif
        send(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
        wait_idle("wrap");

        send(64'h40, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_m_valid", {63'h0, bus.m_valid}, 64'h0);
            chk("zero_busy", {63'h0, busy}, 64'h0);
            chk("zero_s_ready", {63'h0, bus.s_ready}, 64'h1);
        end
        @(posedge clk);
        #1;

        bus.m_ready = 1'b0;
        push(64'h1000, 8'd15);
        push(64'h1400, 8'd3);
        send(64'h1000, 32'd20);
        wait_mvalid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_m_addr", bus.m_addr, 64'h1000);
            chk("stall_m_len", {56'h0, bus.m_len}, 64'd15);
            chk("stall_m_valid", {63'h0, bus.m_valid}, 64'h1);
            chk("stall_s_ready", {63'h0, bus.s_ready}, 64'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        wait_idle("stall");

        bus.m_ready = 1'b0;
        send(64'h2000, 32'd40);
        wait_mvalid("rstmid");
        #2 reset = 1'b1;
        #1;
        chk("rstmid_m_valid", {63'h0, bus.m_valid}, 64'h0);
        chk("rstmid_busy", {63'h0, busy}, 64'h0);
        chk("rstmid_s_ready", {63'h0, bus.s_ready}, 64'h0);
        chk("rstmid_m_addr", bus.m_addr, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_s_ready_back", {63'h0, bus.s_ready}, 64'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rstmid_no_stale", {63'h0, bus.m_valid}, 64'h0);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
